// File: rtl/haz_scoreboard.sv
// rtl/haz_scoreboard.sv - register hazard scoreboard with stall, flush and stall counter
module haz_scoreboard #(
   parameter int NREG        = 32,
   parameter int AW          = $clog2(NREG),
   parameter int LAT_W       = 3,
   parameter int FLUSH_DEPTH = 2,
   parameter int PC_W        = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             D_VALID,
   input  logic [AW-1:0]    D_RS1,
   input  logic [AW-1:0]    D_RS2,
   input  logic             D_USE1,
   input  logic             D_USE2,
   input  logic [AW-1:0]    D_RD,
   input  logic             D_WE,
   input  logic [LAT_W-1:0] D_LAT,
   input  logic             FLUSH_REQ,
   output logic             STALL,
   output logic             FLUSH,
   output logic             ISSUE,
   output logic             BUSY,
   output logic [PC_W-1:0]  STALL_CYCLES
);

   localparam int FW = $clog2(FLUSH_DEPTH + 1);

   logic [LAT_W-1:0] cnt_q [NREG];
   logic [LAT_W-1:0] cnt_d [NREG];
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic [PC_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic raw, waw, flush, stall, issue, busy;

   // Hazard detection; flush and reset mask both stall and issue.
   always_comb begin
      raw   = D_VALID & ((D_USE1 & (cnt_q[D_RS1] != '0)) |
                         (D_USE2 & (cnt_q[D_RS2] != '0)));
      waw   = D_VALID & D_WE & (D_RD != '0) & (cnt_q[D_RD] > D_LAT);
      flush = (fcnt_q != '0) & RST_N;
      stall = (raw | waw) & ~flush & RST_N;
      issue = D_VALID & ~stall & ~flush & RST_N;
   end

   // Pending counters age by one each cycle; an issuing writer reloads its entry.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      end
      cnt_d[0] = '0;
      if (issue && D_WE && (D_RD != '0)) begin
         cnt_d[D_RD] = D_LAT;
      end
   end

   // Flush window restarts on every request rather than accumulating.
   always_comb begin
      fcnt_d = fcnt_q;
      if (FLUSH_REQ) begin
         fcnt_d = FW'(FLUSH_DEPTH);
      end else if (fcnt_q != '0) begin
         fcnt_d = fcnt_q - FW'(1);
      end
   end

   // Stall cycle counter saturates at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PC_W'(1);
      end
   end

   // Busy reflects registered pending state only.
   always_comb begin
      busy = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         busy = busy | (cnt_q[r] != '0);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= '0;
         end
         fcnt_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         fcnt_q      <= fcnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign STALL        = stall;
   assign FLUSH        = flush;
   assign ISSUE        = issue;
   assign BUSY         = busy;
   assign STALL_CYCLES = stall_cnt_q;

endmodule

// File: tb/tb_haz_scoreboard.sv
// tb/tb_haz_scoreboard.sv - directed self-checking bench for haz_scoreboard
module tb_haz_scoreboard;

   logic       CLK;
   logic       RST_N;
   logic       D_VALID;
   logic [4:0] D_RS1, D_RS2, D_RD;
   logic       D_USE1, D_USE2, D_WE;
   logic [2:0] D_LAT;
   logic       FLUSH_REQ;
   logic       STALL, FLUSH, ISSUE, BUSY;
   logic [3:0] STALL_CYCLES;

   int n_checks = 0;
   int n_pass   = 0;

   haz_scoreboard #(.PC_W(4)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .D_VALID      (D_VALID),
      .D_RS1        (D_RS1),
      .D_RS2        (D_RS2),
      .D_USE1       (D_USE1),
      .D_USE2       (D_USE2),
      .D_RD         (D_RD),
      .D_WE         (D_WE),
      .D_LAT        (D_LAT),
      .FLUSH_REQ    (FLUSH_REQ),
      .STALL        (STALL),
      .FLUSH        (FLUSH),
      .ISSUE        (ISSUE),
      .BUSY         (BUSY),
      .STALL_CYCLES (STALL_CYCLES)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL timeout: bench did not reach summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      D_VALID = 1'b0; D_RS1 = 5'd0; D_RS2 = 5'd0; D_USE1 = 1'b0; D_USE2 = 1'b0;
      D_RD = 5'd0; D_WE = 1'b0; D_LAT = 3'd0; FLUSH_REQ = 1'b0;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic we,
                        input logic [2:0] lat);
      D_VALID = 1'b1; D_RS1 = rs1; D_USE1 = u1; D_RS2 = rs2; D_USE2 = u2;
      D_RD = rd; D_WE = we; D_LAT = lat;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      idle();
      tick();
      RST_N = 1'b1;
   endtask

   initial begin
      // reset with flush request and valid decode ignored
      RST_N = 1'b0;
      idle();
      instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 3'd4);
      FLUSH_REQ = 1'b1;
      tick();
      tick();
      #1;
      check("rst_stall", 32'(STALL), 32'd0);
      check("rst_flush", 32'(FLUSH), 32'd0);
      check("rst_issue", 32'(ISSUE), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_cycles", 32'(STALL_CYCLES), 32'd0);
      RST_N = 1'b1;
      idle();
      tick();
      #1;
      check("rst_flush_ignored", 32'(FLUSH), 32'd0);

      // load-use: producer lat 2, consumer arrives when one cycle remains
      do_reset();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd2);
      #1; check("lu_prod_issue", 32'(ISSUE), 32'd1);
      tick();
      idle();
      #1; check("lu_busy", 32'(BUSY), 32'd1);
      tick();
      instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      #1; check("lu_stall", 32'(STALL), 32'd1);
      check("lu_no_issue", 32'(ISSUE), 32'd0);
      tick();
      #1; check("lu_stall_clear", 32'(STALL), 32'd0);
      check("lu_issue", 32'(ISSUE), 32'd1);
      check("lu_cycles", 32'(STALL_CYCLES), 32'd1);
      check("lu_idle_busy", 32'(BUSY), 32'd0);
      tick();

      // x0 destination and zero latency leave nothing pending
      do_reset();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd3);
      #1; check("x0_issue", 32'(ISSUE), 32'd1);
      tick();
      instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 3'd0);
      #1; check("x0_stall", 32'(STALL), 32'd0);
      check("x0_busy", 32'(BUSY), 32'd0);
      tick();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 3'd0);
      tick();
      instr(5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 3'd0);
      #1; check("lat0_stall", 32'(STALL), 32'd0);
      check("lat0_busy", 32'(BUSY), 32'd0);
      tick();

      // WAW: older write lat 5, younger write lat 1 waits until cnt <= 1
      do_reset();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd5);
      tick();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1);
      for (int k = 0; k < 4; k++) begin
         #1; check("waw_stall", 32'(STALL), 32'd1);
         tick();
      end
      #1; check("waw_issue", 32'(ISSUE), 32'd1);
      check("waw_eq_no_stall", 32'(STALL), 32'd0);
      tick();
      instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      #1; check("waw_reload_stall", 32'(STALL), 32'd1);
      check("waw_reload_busy", 32'(BUSY), 32'd1);
      tick();
      #1; check("waw_cons_issue", 32'(ISSUE), 32'd1);
      check("waw_cycles", 32'(STALL_CYCLES), 32'd5);
      tick();

      // flush over a RAW hazard, then restart of an active flush
      do_reset();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd7);
      tick();
      instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      FLUSH_REQ = 1'b1;
      #1; check("fl_pre_stall", 32'(STALL), 32'd1);
      check("fl_pre_flush", 32'(FLUSH), 32'd0);
      tick();
      FLUSH_REQ = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1; check("fl_flush", 32'(FLUSH), 32'd1);
         check("fl_no_stall", 32'(STALL), 32'd0);
         check("fl_no_issue", 32'(ISSUE), 32'd0);
         tick();
      end
      #1; check("fl_end", 32'(FLUSH), 32'd0);
      check("fl_still_stall", 32'(STALL), 32'd1);
      check("fl_busy", 32'(BUSY), 32'd1);
      FLUSH_REQ = 1'b1;
      tick();
      #1; check("fl2_flush_a", 32'(FLUSH), 32'd1);
      tick();
      FLUSH_REQ = 1'b0;
      #1; check("fl2_flush_b", 32'(FLUSH), 32'd1);
      check("fl2_no_issue", 32'(ISSUE), 32'd0);
      tick();
      #1; check("fl2_flush_c", 32'(FLUSH), 32'd1);
      tick();
      #1; check("fl2_end", 32'(FLUSH), 32'd0);
      check("fl2_issue", 32'(ISSUE), 32'd1);
      check("fl2_cycles", 32'(STALL_CYCLES), 32'd2);
      tick();

      // reset mid-operation: cnt[3]=4, fcnt=1, STALL_CYCLES=9
      do_reset();
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd7);
      tick();
      instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 3'd7);
      repeat (7) tick();
      #1; check("mr_prod_issue", 32'(ISSUE), 32'd1);
      tick();
      instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
      #1; check("mr_stall", 32'(STALL), 32'd1);
      tick();
      FLUSH_REQ = 1'b1;
      tick();
      FLUSH_REQ = 1'b0;
      tick();
      #1; check("mr_pre_cycles", 32'(STALL_CYCLES), 32'd9);
      check("mr_pre_flush", 32'(FLUSH), 32'd1);
      check("mr_pre_busy", 32'(BUSY), 32'd1);
      RST_N = 1'b0;
      #1; check("mr_rst_flush", 32'(FLUSH), 32'd0);
      check("mr_rst_issue", 32'(ISSUE), 32'd0);
      check("mr_rst_stall", 32'(STALL), 32'd0);
      tick();
      RST_N = 1'b1;
      #1; check("mr_busy", 32'(BUSY), 32'd0);
      check("mr_flush", 32'(FLUSH), 32'd0);
      check("mr_stall_after", 32'(STALL), 32'd0);
      check("mr_issue", 32'(ISSUE), 32'd1);
      check("mr_cycles", 32'(STALL_CYCLES), 32'd0);
      tick();

      // stall counter saturation with PC_W=4
      do_reset();
      instr(5'd10, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 3'd7);
      repeat (17) tick();
      #1; check("sat_cycles_14", 32'(STALL_CYCLES), 32'd14);
      check("sat_stall", 32'(STALL), 32'd1);
      repeat (13) tick();
      #1; check("sat_cycles_15", 32'(STALL_CYCLES), 32'd15);
      check("sat_stall_held", 32'(STALL), 32'd1);
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
